alien_projectile_pool: RTL and testbench
========================================

Name: alien_projectile_pool

Overview:
- Multi-slot successor to the single alien projectile. Owns NUM_SLOTS independent downward-moving alien shots.
- Runs on the system clock and detects frame ticks internally from vsync.
- Arbitrates spawn requests onto the lowest free slot, enforces a frame-based fire cooldown, clears slots on hit, and renders all shots into one gfx bit plus the slot index for collision attribution.
- Sits between the alien-formation shooter logic and the cannon collision / pixel mux.

Parameters:
- NUM_SLOTS, 4: number of concurrent projectiles (1..8).
- LOWER_BORDER, 480: y beyond which a shot retires.
- SCALING, 4: pixel scale of the sprite.
- SPEED, 6: y increment per frame tick.
- COOLDOWN_FRAMES, 20: minimum frame ticks between accepted spawns (0 = none).
- SPRITE_W, 3 / SPRITE_H, 5: sprite size in scaled cells.

Ports:
- clock  in  1  system pixel clock.
- reset  in  1  asynchronous, active-high reset.
- vpos  in  10  current beam row.
- hpos  in  10  current beam column.
- vsync  in  1  raw vsync level, synchronous to clock.
- shoot  in  1  spawn request (level, held until shoot_ack).
- alien_x  in  10  spawn x, sampled on acceptance.
- alien_y  in  10  spawn y, sampled on acceptance.
- hit_mask  in  NUM_SLOTS  per-slot clear request (cannon/shield hit).
- shoot_ack  out  1  one-cycle pulse: request accepted.
- active_mask  out  NUM_SLOTS  slot i in flight.
- proj_x  out  NUM_SLOTS*10  packed x, slot i at [10*i+:10].
- proj_y  out  NUM_SLOTS*10  packed y, same packing.
- projectile_gfx  out  1  beam is on any active shot's lit pixel.
- gfx_slot  out  3  lowest slot index lighting the current pixel; 0 when gfx low.

Behaviour:
- Reset, asynchronous and active-high. Clears: all active bits, frame bits, x/y to 0, cooldown to 0, vsync_q to 0, shoot_ack to 0.
- frame_tick = vsync & ~vsync_q, where vsync_q is registered vsync. Exactly one tick per rising vsync.
- Accept condition in a cycle: shoot & any slot free (from registered active_mask) & cooldown==0 & !shoot_ack.
- On accept:
  - Lowest free index s is loaded with alien_x/alien_y.
  - active[s] is set and frame[s] is cleared.
  - cooldown is loaded with COOLDOWN_FRAMES.
  - shoot_ack pulses high the next cycle, coincident with active_mask[s]=1.
  - The !shoot_ack term blocks double acceptance of a held request.
- Cooldown decrements by 1 on frame_tick when nonzero. It saturates at 0.
- Per active slot on frame_tick:
  - If y > LOWER_BORDER: deactivate.
  - Else: y <= y + SPEED and frame toggles.
- hit_mask[i] high in any cycle deactivates slot i next cycle. It has priority over the tick update. Hits on inactive slots are ignored.
- Simultaneous events:
  - A slot cleared this cycle is not spawn-eligible until the next cycle.
  - A slot spawned on a tick cycle is not advanced by that tick.
  - Cooldown load wins over decrement.
- Width: 10-bit unsigned throughout. Elaboration assertion: LOWER_BORDER+SPEED < 1024, so y never wraps.
- Render, combinational per slot:
  - dx = hpos - x, dy = vpos - y.
  - In sprite when active, hpos>=x, vpos>=y, dx/SCALING < SPRITE_W, and dy/SCALING < SPRITE_H.
  - Lit when sx == SPRITE_W/2, or sy == (frame ? 1 : SPRITE_H-2).
- projectile_gfx = OR of lit. gfx_slot = priority encode of lit.
- Reset mid-flight: all slots vanish immediately, with no ack pulse.

Decomposition:
- Package alien_projectile_pkg holds:
  - proj_slot_t struct (active, frame, x, y).
  - Constants for 10-bit coordinate width and maximum slot count 8.
  - A function for the lit-pixel test.
- One natural sub-module, alien_projectile_slot, instantiated NUM_SLOTS times by generate. It holds slot state, movement, and render. The top keeps the vsync edge detector, spawn arbiter, cooldown counter, and gfx OR/encode.

Test Plan:
- Reset, then shoot=1 with alien_x=100, alien_y=50, COOLDOWN_FRAMES=0 -> shoot_ack pulse one cycle later; active_mask=4'b0001; proj_x[0]=100, proj_y[0]=50.
- Hold shoot with COOLDOWN_FRAMES=2 -> next accept only after 2 vsync rising edges; it fills slot 1, and slot 0 has y=62.
- Fill all 4 slots, keep shoot high -> no ack; hit_mask=4'b0100 -> slot 2 clears; ack on the following cycle refills slot 2 only.
- Slot at y=480 then tick -> y=486; next tick -> retired, active bit 0.
- hit_mask[0] asserted on the same cycle as frame_tick -> slot 0 clears, no move. Spawn requested that cycle -> goes to slot 1.
- Shot at x=200, y=100, frame=0, beam hpos=204, vpos=112 -> projectile_gfx=1, gfx_slot=0. Beam hpos=200, vpos=104 -> gfx=0. Assert reset mid-frame -> gfx=0 and active_mask=0 immediately.

Source files
------------

// File: rtl/alien_projectile_pkg.sv
// Shared types, widths and the sprite lit-pixel test for the alien projectile pool.
package alien_projectile_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_SLOTS = 8;

    typedef struct packed {
        logic               active;
        logic               frame;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } proj_slot_t;

    // Sprite is a vertical bar down the middle column plus one crossbar row
    // that alternates position with the animation frame.
    function automatic logic pixel_lit(
        input logic [COORD_W-1:0] sx,
        input logic [COORD_W-1:0] sy,
        input logic               frame,
        input logic [COORD_W-1:0] sprite_w,
        input logic [COORD_W-1:0] sprite_h
    );
        logic [COORD_W-1:0] bar_row;
        bar_row = frame ? COORD_W'(1) : sprite_h - COORD_W'(2);
        return (sx == (sprite_w >> 1)) || (sy == bar_row);
    endfunction

endpackage

// File: rtl/alien_projectile_pool_slot.sv
// One projectile slot: holds position/animation state, moves on frame ticks,
// and reports whether the beam is on one of its lit pixels.
module alien_projectile_slot
    import alien_projectile_pkg::*;
#(
    parameter int LOWER_BORDER = 480,
    parameter int SCALING      = 4,
    parameter int SPEED        = 6,
    parameter int SPRITE_W     = 3,
    parameter int SPRITE_H     = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               hit,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               lit
);

    localparam logic [COORD_W-1:0] SCALE_C  = COORD_W'(SCALING);
    localparam logic [COORD_W-1:0] SPEED_C  = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] BORDER_C = COORD_W'(LOWER_BORDER);
    localparam logic [COORD_W-1:0] SPR_W_C  = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SPR_H_C  = COORD_W'(SPRITE_H);

    proj_slot_t state;

    logic [COORD_W-1:0] dx, dy, sx, sy;
    logic               in_sprite;

    // Slot state: spawn loads a fresh shot, hit retires it, tick moves or retires it.
    // NOTE: sequential state uses non-blocking assignments so every slot sees the
    // same pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (spawn) begin
            // A fresh shot is not advanced by a tick that lands on its spawn cycle.
            state.active <= 1'b1;
            state.frame  <= 1'b0;
            state.x      <= spawn_x;
            state.y      <= spawn_y;
        end else if (hit && state.active) begin
            state.active <= 1'b0;
        end else if (frame_tick && state.active) begin
            if (state.y > BORDER_C) begin
                state.active <= 1'b0;
            end else begin
                state.y     <= state.y + SPEED_C;
                state.frame <= ~state.frame;
            end
        end
    end

    assign dx = hpos - state.x;
    assign dy = vpos - state.y;
    assign sx = dx / SCALE_C;
    assign sy = dy / SCALE_C;

    // Render: beam inside this shot's sprite box and on one of its lit cells.
    always_comb begin
        in_sprite = state.active && (hpos >= state.x) && (vpos >= state.y)
                    && (sx < SPR_W_C) && (sy < SPR_H_C);
        lit       = in_sprite && pixel_lit(sx, sy, state.frame, SPR_W_C, SPR_H_C);
    end

    assign active = state.active;
    assign x      = state.x;
    assign y      = state.y;

endmodule

// File: rtl/alien_projectile_pool.sv
// Pool of alien shots: vsync edge detect, lowest-free-slot spawn arbiter,
// frame-based fire cooldown, and merged gfx output with slot attribution.
module alien_projectile_pool
    import alien_projectile_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int LOWER_BORDER    = 480,
    parameter int SCALING         = 4,
    parameter int SPEED           = 6,
    parameter int COOLDOWN_FRAMES = 20,
    parameter int SPRITE_W        = 3,
    parameter int SPRITE_H        = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COORD_W-1:0]           vpos,
    input  logic [COORD_W-1:0]           hpos,
    input  logic                         vsync,
    input  logic                         shoot,
    input  logic [COORD_W-1:0]           alien_x,
    input  logic [COORD_W-1:0]           alien_y,
    input  logic [NUM_SLOTS-1:0]         hit_mask,
    output logic                         shoot_ack,
    output logic [NUM_SLOTS-1:0]         active_mask,
    output logic [NUM_SLOTS*COORD_W-1:0] proj_x,
    output logic [NUM_SLOTS*COORD_W-1:0] proj_y,
    output logic                         projectile_gfx,
    output logic [2:0]                   gfx_slot
);

    localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    if (LOWER_BORDER + SPEED >= 1024) begin : g_bad_border
        $error("LOWER_BORDER + SPEED must stay below 1024 so y cannot wrap");
    end
    if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS) begin : g_bad_slots
        $error("NUM_SLOTS must be in 1..8");
    end

    logic                 vsync_q;
    logic                 frame_tick;
    logic [CD_W-1:0]      cooldown;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] lowest_free;
    logic [NUM_SLOTS-1:0] spawn_vec;
    logic [NUM_SLOTS-1:0] lit_vec;
    logic                 accept;

    assign frame_tick = vsync & ~vsync_q;

    // Arbiter: eligibility comes from the registered mask, so a slot freed this
    // cycle only becomes spawnable next cycle; the ack term stops a held request
    // being taken twice.
    always_comb begin
        free_mask   = ~active_mask;
        lowest_free = free_mask & (~free_mask + NUM_SLOTS'(1));
        accept      = shoot && (|free_mask) && (cooldown == '0) && !shoot_ack;
        spawn_vec   = accept ? lowest_free : '0;
    end

    // vsync edge detector, cooldown counter (load beats decrement) and ack pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            cooldown  <= '0;
            shoot_ack <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            shoot_ack <= accept;
            if (accept) begin
                cooldown <= CD_W'(COOLDOWN_FRAMES);
            end else if (frame_tick && cooldown != '0) begin
                cooldown <= cooldown - CD_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        alien_projectile_slot #(
            .LOWER_BORDER (LOWER_BORDER),
            .SCALING      (SCALING),
            .SPEED        (SPEED),
            .SPRITE_W     (SPRITE_W),
            .SPRITE_H     (SPRITE_H)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .frame_tick (frame_tick),
            .spawn      (spawn_vec[i]),
            .spawn_x    (alien_x),
            .spawn_y    (alien_y),
            .hit        (hit_mask[i]),
            .hpos       (hpos),
            .vpos       (vpos),
            .active     (active_mask[i]),
            .x          (proj_x[COORD_W*i +: COORD_W]),
            .y          (proj_y[COORD_W*i +: COORD_W]),
            .lit        (lit_vec[i])
        );
    end

    // Merge shots into one gfx bit and report the lowest lit slot.
    // NOTE: gfx_slot gets a default before the loop so no latch is inferred.
    always_comb begin
        projectile_gfx = |lit_vec;
        gfx_slot       = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (lit_vec[i]) gfx_slot = 3'(i);
        end
    end

endmodule

// File: tb/tb_alien_projectile_pool.sv
// Directed self-checking bench for alien_projectile_pool (4 slots, cooldown 2).
module tb_alien_projectile_pool;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  vpos = '0;
    logic [9:0]  hpos = '0;
    logic        vsync = 1'b0;
    logic        shoot = 1'b0;
    logic [9:0]  alien_x = '0;
    logic [9:0]  alien_y = '0;
    logic [3:0]  hit_mask = '0;
    logic        shoot_ack;
    logic [3:0]  active_mask;
    logic [39:0] proj_x;
    logic [39:0] proj_y;
    logic        projectile_gfx;
    logic [2:0]  gfx_slot;

    int n_assert = 0;
    int n_fail   = 0;

    alien_projectile_pool #(
        .NUM_SLOTS       (4),
        .LOWER_BORDER    (480),
        .SCALING         (4),
        .SPEED           (6),
        .COOLDOWN_FRAMES (2),
        .SPRITE_W        (3),
        .SPRITE_H        (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .vpos           (vpos),
        .hpos           (hpos),
        .vsync          (vsync),
        .shoot          (shoot),
        .alien_x        (alien_x),
        .alien_y        (alien_y),
        .hit_mask       (hit_mask),
        .shoot_ack      (shoot_ack),
        .active_mask    (active_mask),
        .proj_x         (proj_x),
        .proj_y         (proj_y),
        .projectile_gfx (projectile_gfx),
        .gfx_slot       (gfx_slot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // One rising vsync edge followed by a low cycle.
    task automatic tick();
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        cycle();
    endtask

    function automatic logic [9:0] px(input int i);
        return proj_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] py(input int i);
        return proj_y[10*i +: 10];
    endfunction

    initial begin
        // Reset state
        cycle();
        cycle();
        check("reset_active", 40'(active_mask), 40'h0);
        check("reset_ack", 40'(shoot_ack), 40'h0);
        check("reset_gfx", 40'(projectile_gfx), 40'h0);
        reset = 1'b0;
        cycle();

        // First spawn: accepted immediately, ack next cycle with slot 0 live
        alien_x = 10'd100;
        alien_y = 10'd50;
        shoot   = 1'b1;
        cycle();
        check("spawn0_ack", 40'(shoot_ack), 40'h1);
        check("spawn0_mask", 40'(active_mask), 40'h1);
        check("spawn0_x", 40'(px(0)), 40'd100);
        check("spawn0_y", 40'(py(0)), 40'd50);
        cycle();
        check("ack_one_cycle", 40'(shoot_ack), 40'h0);

        // Held request waits for two vsync rising edges of cooldown
        tick();
        check("cooldown_hold_mask", 40'(active_mask), 40'h1);
        check("slot0_y_after_1tick", 40'(py(0)), 40'd56);
        alien_x = 10'd120;
        alien_y = 10'd60;
        tick();
        check("spawn1_ack", 40'(shoot_ack), 40'h1);
        check("spawn1_mask", 40'(active_mask), 40'h3);
        check("spawn1_x", 40'(px(1)), 40'd120);
        check("slot0_y_62", 40'(py(0)), 40'd62);

        // Fill slots 2 and 3
        shoot = 1'b0;
        tick();
        tick();
        alien_x = 10'd300;
        alien_y = 10'd10;
        shoot   = 1'b1;
        cycle();
        check("spawn2_x", 40'(px(2)), 40'd300);
        shoot = 1'b0;
        tick();
        tick();
        alien_x = 10'd310;
        alien_y = 10'd20;
        shoot   = 1'b1;
        cycle();
        check("full_mask", 40'(active_mask), 40'hF);
        tick();
        tick();
        check("full_no_ack", 40'(shoot_ack), 40'h0);

        // Hit slot 2 while the request is held: clear first, refill a cycle later
        alien_x  = 10'd400;
        alien_y  = 10'd30;
        hit_mask = 4'b0100;
        cycle();
        check("hit2_mask", 40'(active_mask), 40'hB);
        check("hit2_no_ack", 40'(shoot_ack), 40'h0);
        hit_mask = '0;
        cycle();
        check("refill2_ack", 40'(shoot_ack), 40'h1);
        check("refill2_mask", 40'(active_mask), 40'hF);
        check("refill2_x", 40'(px(2)), 40'd400);
        check("slot3_x_kept", 40'(px(3)), 40'd310);
        shoot = 1'b0;

        // Free slot 1, let cooldown expire (slot 0 reaches y=110)
        hit_mask = 4'b0010;
        cycle();
        hit_mask = '0;
        tick();
        tick();
        check("slot0_y_110", 40'(py(0)), 40'd110);

        // Hit on slot 0 coincides with a tick and a spawn request
        vsync    = 1'b1;
        hit_mask = 4'b0001;
        shoot    = 1'b1;
        alien_x  = 10'd500;
        alien_y  = 10'd40;
        cycle();
        check("hit_tick_mask", 40'(active_mask), 40'hE);
        check("hit_tick_y0_nomove", 40'(py(0)), 40'd110);
        check("spawn_on_tick_y1", 40'(py(1)), 40'd40);
        check("spawn_on_tick_x1", 40'(px(1)), 40'd500);
        vsync    = 1'b0;
        hit_mask = '0;
        shoot    = 1'b0;
        cycle();

        // Lower border: y=480 still moves, 486 retires
        tick();
        tick();
        alien_x = 10'd50;
        alien_y = 10'd480;
        shoot   = 1'b1;
        cycle();
        shoot = 1'b0;
        check("border_spawn_mask", 40'(active_mask), 40'hF);
        tick();
        check("border_y_486", 40'(py(0)), 40'd486);
        check("border_still_active", 40'(active_mask[0]), 40'h1);
        tick();
        check("border_retired", 40'(active_mask[0]), 40'h0);

        // Slot attribution: slot 1 at (500,64), beam on its centre column
        hpos = 10'd505;
        vpos = 10'd66;
        #1;
        check("slot1_gfx", 40'(projectile_gfx), 40'h1);
        check("slot1_gfx_slot", 40'(gfx_slot), 40'd1);

        // Rendering from a clean reset
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_clear_mask", 40'(active_mask), 40'h0);
        alien_x = 10'd200;
        alien_y = 10'd100;
        shoot   = 1'b1;
        cycle();
        shoot = 1'b0;
        hpos = 10'd204;
        vpos = 10'd112;
        #1;
        check("render_lit", 40'(projectile_gfx), 40'h1);
        check("render_slot0", 40'(gfx_slot), 40'd0);
        hpos = 10'd200;
        vpos = 10'd104;
        #1;
        check("render_dark", 40'(projectile_gfx), 40'h0);
        check("render_dark_slot", 40'(gfx_slot), 40'd0);
        hpos = 10'd200;
        vpos = 10'd112;
        #1;
        check("render_bar_f0", 40'(projectile_gfx), 40'h1);
        hpos = 10'd199;
        #1;
        check("render_left_of_x", 40'(projectile_gfx), 40'h0);

        // After a tick the shot is at y=106 with frame=1: bar on sprite row 1
        cycle();
        tick();
        hpos = 10'd200;
        vpos = 10'd110;
        #1;
        check("render_bar_f1", 40'(projectile_gfx), 40'h1);

        // Reset mid-frame clears everything without waiting for a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("midrst_gfx", 40'(projectile_gfx), 40'h0);
        check("midrst_mask", 40'(active_mask), 40'h0);
        check("midrst_ack", 40'(shoot_ack), 40'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
